// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder.
// Write-buffer entry layout and load-result source selector.
package dmem_responder_pkg;

  localparam int DMEM_ADDR_W   = 10;
  localparam int DMEM_WB_DEPTH = 4;

  typedef struct packed {
    logic                   valid;
    logic [DMEM_ADDR_W-1:0] index;
    logic [31:0]            data;
  } wbuf_entry_t;

  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_FWD,
    SRC_ARR
  } rd_src_t;

endpackage

// File: rtl/dmem_wbuf.sv
// Posted write buffer: circular FIFO of {index, data} entries
// with a combinational youngest-match lookup for load forwarding.
module dmem_wbuf
  import dmem_responder_pkg::*;
#(
  parameter  int ADDR_W = DMEM_ADDR_W,
  parameter  int DEPTH  = DMEM_WB_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_index,
  input  logic [31:0]       push_data,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_index,
  output logic [31:0]       head_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] lk_index,
  output logic              lk_hit,
  output logic [31:0]       lk_data
);

  wbuf_entry_t      ents [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] pos;

  assign full       = (count == CNT_W'(DEPTH));
  assign empty      = (count == '0);
  assign head_index = ADDR_W'(ents[head].index);
  assign head_data  = ents[head].data;

  // FIFO state; a push into the slot being popped (full + drain) wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ents[i] <= '0;
      end
    end else begin
      if (pop) begin
        ents[head].valid <= 1'b0;
        head             <= head + 1'b1;
      end
      if (push) begin
        ents[tail] <= '{
          valid: 1'b1,
          index: DMEM_ADDR_W'(push_index),
          data:  push_data
        };
        tail <= tail + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    pos     = head;
    for (int k = 0; k < DEPTH; k++) begin
      pos = head + PTR_W'(k);
      if (ents[pos].valid &&
          ents[pos].index == DMEM_ADDR_W'(lk_index)) begin
        lk_hit  = 1'b1;
        lk_data = ents[pos].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: 1-cycle loads, posted stores drained
// into a single-port word array when the port is free.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter  int ADDR_W   = DMEM_ADDR_W,
  parameter  int WB_DEPTH = DMEM_WB_DEPTH,
  localparam int CNT_W    = $clog2(WB_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_w_data,
  input  logic        mem_we,
  input  logic        mem_oe,
  output logic [31:0] mem_r_data,
  output logic        stall,
  output logic        wb_empty,
  output logic        addr_err
);

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic              in_range;
  logic              drain;
  logic              push;
  logic              wb_full;
  logic              wb_is_empty;
  logic [CNT_W-1:0]  wb_count;
  logic [ADDR_W-1:0] drain_index;
  logic [31:0]       drain_data;
  logic              lk_hit;
  logic [31:0]       lk_data;
  logic [31:0]       arr_q;
  logic [31:0]       fwd_q;
  rd_src_t           rd_src;
  logic              unused_addr;

  assign idx         = mem_addr[ADDR_W+1:2];
  assign in_range    = (mem_addr[31:ADDR_W+2] == '0);
  assign unused_addr = ^mem_addr[1:0];

  // Loads own the array port; drains only use idle cycles.
  assign drain    = ~mem_oe & ~wb_is_empty;
  assign stall    = mem_we & in_range & wb_full & ~drain;
  assign push     = mem_we & in_range & ~stall;
  assign wb_empty = (wb_count == '0);

  dmem_wbuf #(
    .ADDR_W (ADDR_W),
    .DEPTH  (WB_DEPTH)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_index (idx),
    .push_data  (mem_w_data),
    .pop        (drain),
    .head_index (drain_index),
    .head_data  (drain_data),
    .full       (wb_full),
    .empty      (wb_is_empty),
    .count      (wb_count),
    .lk_index   (idx),
    .lk_hit     (lk_hit),
    .lk_data    (lk_data)
  );

  // Single-port array: read for a load, else write the drained entry.
  always_ff @(posedge clk) begin
    if (mem_oe) begin
      arr_q <= mem[idx];
    end else if (drain) begin
      mem[drain_index] <= drain_data;
    end
  end

  // Remember where this load's result comes from; flag bad addresses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_src   <= SRC_ZERO;
      fwd_q    <= '0;
      addr_err <= 1'b0;
    end else begin
      if (mem_oe) begin
        unique case (1'b1)
          ~in_range:          rd_src <= SRC_ZERO;
          in_range & lk_hit:  begin
            rd_src <= SRC_FWD;
            fwd_q  <= lk_data;
          end
          in_range & ~lk_hit: rd_src <= SRC_ARR;
        endcase
      end
      if ((mem_oe | mem_we) & ~in_range) begin
        addr_err <= 1'b1;
      end
    end
  end

  // Select the registered load result.
  always_comb begin
    mem_r_data = '0;
    case (rd_src)
      SRC_FWD: mem_r_data = fwd_q;
      SRC_ARR: mem_r_data = arr_q;
      default: mem_r_data = '0;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder.
// Each task drives one scenario and checks inline.
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic [31:0] mem_addr;
  logic [31:0] mem_w_data;
  logic        mem_we;
  logic        mem_oe;
  logic [31:0] mem_r_data;
  logic        stall;
  logic        wb_empty;
  logic        addr_err;

  int total = 0;
  int bad   = 0;

  dmem_responder #(
    .ADDR_W   (10),
    .WB_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_we     (mem_we),
    .mem_oe     (mem_oe),
    .mem_r_data (mem_r_data),
    .stall      (stall),
    .wb_empty   (wb_empty),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic oe, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    mem_oe     = oe;
    mem_we     = we;
    mem_addr   = a;
    mem_w_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    #3;
    total++;
    if (mem_r_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_rdata got=%h exp=%h", mem_r_data, 32'h0);
    end
    total++;
    if (wb_empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_wb_empty got=%b exp=1", wb_empty);
    end
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_addr_err got=%b exp=0", addr_err);
    end
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall got=%b exp=0", stall);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_drain_load();
    drive(1'b0, 1'b1, 32'h40, 32'h1234_5678);
    tick();
    total++;
    if (wb_empty !== 1'b0) begin
      bad++;
      $display("FAIL sdl_pushed got=%b exp=0", wb_empty);
    end
    idle(2);
    total++;
    if (wb_empty !== 1'b1) begin
      bad++;
      $display("FAIL sdl_drained got=%b exp=1", wb_empty);
    end
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'h1234_5678) begin
      bad++;
      $display("FAIL sdl_load got=%h exp=%h", mem_r_data, 32'h1234_5678);
    end
    idle(1);
  endtask

  task automatic test_forward();
    drive(1'b0, 1'b1, 32'h80, 32'hA);
    tick();
    drive(1'b1, 1'b0, 32'h80, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'hA) begin
      bad++;
      $display("FAIL fwd_load got=%h exp=%h", mem_r_data, 32'hA);
    end
    total++;
    if (wb_empty !== 1'b0) begin
      bad++;
      $display("FAIL fwd_not_drained got=%b exp=0", wb_empty);
    end
    idle(2);
  endtask

  task automatic test_youngest();
    drive(1'b0, 1'b1, 32'h10, 32'h1);
    tick();
    drive(1'b0, 1'b1, 32'h10, 32'h2);
    tick();
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'h2) begin
      bad++;
      $display("FAIL young_fwd got=%h exp=%h", mem_r_data, 32'h2);
    end
    idle(3);
    total++;
    if (wb_empty !== 1'b1) begin
      bad++;
      $display("FAIL young_drained got=%b exp=1", wb_empty);
    end
    drive(1'b1, 1'b0, 32'h10, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'h2) begin
      bad++;
      $display("FAIL young_array got=%h exp=%h", mem_r_data, 32'h2);
    end
    idle(1);
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 32'h100 + 32'(4 * i), 32'hB0 + 32'(i));
      tick();
    end
    drive(1'b0, 1'b1, 32'h0, 32'h55);
    tick();
    idle(6);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hC0 + 32'(i));
      #1;
      total++;
      if (stall !== 1'b0) begin
        bad++;
        $display("FAIL stall_fill%0d got=%b exp=0", i, stall);
      end
      tick();
      total++;
      if (mem_r_data !== 32'hB0 + 32'(i)) begin
        bad++;
        $display("FAIL stall_old%0d got=%h exp=%h",
                 i, mem_r_data, 32'hB0 + 32'(i));
      end
    end
    drive(1'b1, 1'b1, 32'h110, 32'hC4);
    #1;
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL stall_full got=%b exp=1", stall);
    end
    tick();
    total++;
    if (mem_r_data !== 32'hB4) begin
      bad++;
      $display("FAIL stall_load got=%h exp=%h", mem_r_data, 32'hB4);
    end
    total++;
    if (stall !== 1'b1) begin
      bad++;
      $display("FAIL stall_held got=%b exp=1", stall);
    end
    drive(1'b0, 1'b1, 32'h110, 32'hC4);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL stall_drain got=%b exp=0", stall);
    end
    tick();
    idle(3);
    total++;
    if (wb_empty !== 1'b0) begin
      bad++;
      $display("FAIL stall_cnt4 got=%b exp=0", wb_empty);
    end
    idle(1);
    total++;
    if (wb_empty !== 1'b1) begin
      bad++;
      $display("FAIL stall_empty got=%b exp=1", wb_empty);
    end
    drive(1'b1, 1'b0, 32'h110, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'hC4) begin
      bad++;
      $display("FAIL stall_rd110 got=%h exp=%h", mem_r_data, 32'hC4);
    end
    drive(1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'hC0) begin
      bad++;
      $display("FAIL stall_rd100 got=%h exp=%h", mem_r_data, 32'hC0);
    end
    idle(1);
  endtask

  task automatic test_addr_err();
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL aerr_clear got=%b exp=0", addr_err);
    end
    drive(1'b1, 1'b0, 32'h0001_0000, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'h0) begin
      bad++;
      $display("FAIL aerr_rdata got=%h exp=%h", mem_r_data, 32'h0);
    end
    total++;
    if (addr_err !== 1'b1) begin
      bad++;
      $display("FAIL aerr_set got=%b exp=1", addr_err);
    end
    drive(1'b0, 1'b1, 32'h0001_0000, 32'h99);
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL aerr_stall got=%b exp=0", stall);
    end
    tick();
    total++;
    if (wb_empty !== 1'b1) begin
      bad++;
      $display("FAIL aerr_nopush got=%b exp=1", wb_empty);
    end
    idle(2);
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'h55) begin
      bad++;
      $display("FAIL aerr_word0 got=%h exp=%h", mem_r_data, 32'h55);
    end
    total++;
    if (addr_err !== 1'b1) begin
      bad++;
      $display("FAIL aerr_sticky got=%b exp=1", addr_err);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'h11 * 32'(i + 1));
      tick();
    end
    idle(4);
    drive(1'b1, 1'b1, 32'h200, 32'hAA);
    tick();
    drive(1'b1, 1'b1, 32'h204, 32'hBB);
    tick();
    drive(1'b1, 1'b1, 32'h208, 32'hCC);
    tick();
    total++;
    if (mem_r_data !== 32'h33) begin
      bad++;
      $display("FAIL rmd_preload got=%h exp=%h", mem_r_data, 32'h33);
    end
    idle(1);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (wb_empty !== 1'b1) begin
      bad++;
      $display("FAIL rmd_empty got=%b exp=1", wb_empty);
    end
    total++;
    if (mem_r_data !== 32'h0) begin
      bad++;
      $display("FAIL rmd_rdata got=%h exp=%h", mem_r_data, 32'h0);
    end
    total++;
    if (addr_err !== 1'b0) begin
      bad++;
      $display("FAIL rmd_aerr got=%b exp=0", addr_err);
    end
    tick();
    rst = 1'b0;
    tick();
    drive(1'b1, 1'b0, 32'h204, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'h22) begin
      bad++;
      $display("FAIL rmd_rd204 got=%h exp=%h", mem_r_data, 32'h22);
    end
    drive(1'b1, 1'b0, 32'h208, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'h33) begin
      bad++;
      $display("FAIL rmd_rd208 got=%h exp=%h", mem_r_data, 32'h33);
    end
    drive(1'b1, 1'b0, 32'h200, 32'h0);
    tick();
    total++;
    if (mem_r_data !== 32'hAA) begin
      bad++;
      $display("FAIL rmd_rd200 got=%h exp=%h", mem_r_data, 32'hAA);
    end
    idle(1);
  endtask

  initial begin
    test_reset();
    test_store_drain_load();
    test_forward();
    test_youngest();
    test_stall();
    test_addr_err();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined core's data port: services loads with fixed 1-cycle latency and accepts stores into a posted write buffer.
- Buffered stores drain into a single-port word array in cycles with no load.
- Loads forward from the buffer, so read-after-write through the buffer is coherent.
- Raises a stall toward the core only when a store cannot be accepted.

Parameters:
- ADDR_W, 10, word-address width; array holds 2**ADDR_W 32-bit words.
- WB_DEPTH, 4, write-buffer entries; power of two, >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- mem_addr  in  32  byte address from core; bits [1:0] ignored.
- mem_w_data  in  32  store data.
- mem_we  in  1  store request.
- mem_oe  in  1  load request.
- mem_r_data  out  32  load data, registered.
- stall  out  1  store not accepted this cycle; core holds request.
- wb_empty  out  1  write buffer empty.
- addr_err  out  1  sticky out-of-range access flag.

Behaviour:
- Word index = mem_addr[ADDR_W+1:2].
- In range: mem_addr[31:ADDR_W+2] == 0.
- Reset (async, immediate):
  - buffer empty; head/tail/count = 0.
  - mem_r_data = 0, addr_err = 0, wb_empty = 1.
  - Array contents not reset.
  - Reset mid-drain: pending stores discarded; no array write occurs after rst rises.
- Load:
  - mem_oe=1 in cycle N -> mem_r_data valid in cycle N+1; held until next load.
  - Source priority:
    - youngest valid buffer entry with matching index;
    - else array content at the start of cycle N.
  - Array read uses the port in cycle N, so no drain that cycle.
  - Out of range: returns 0, sets addr_err.
- Store:
  - mem_we=1 and accepted -> entry {index, data} pushed at tail at end of cycle.
  - Out of range: not pushed, sets addr_err, stall=0.
- Drain:
  - Condition: mem_oe=0 and buffer non-empty.
  - Action: head entry written to array, head advances.
  - At most one drain per cycle.
  - FIFO order preserved; duplicate indices both drain, so the last one wins.
- Stall (combinational):
  - stall = mem_we & in_range & full & ~drain_this_cycle.
  - Full with a simultaneous drain (mem_oe=0): push accepted, count unchanged.
- Simultaneous mem_oe and mem_we:
  - Both serviced.
  - Load sees state before this cycle's store (store not forwarded to itself).
  - No drain that cycle; stall if full.
- Count:
  - +1 on push only, -1 on drain only, unchanged on both.
  - Pointers wrap modulo WB_DEPTH.
- wb_empty = (count==0), registered view of count.
- addr_err: sticky until reset.

Decomposition:
- Shared package (defines): DMEM_ADDR_W and DMEM_WB_DEPTH defaults, and a wbuf entry struct {valid, index[ADDR_W-1:0], data[31:0]}.
- Sub-module dmem_wbuf:
  - circular FIFO with push/pop, full/empty/count;
  - combinational youngest-match lookup port (hit, data).
- Top level:
  - array and its port arbitration (load > drain);
  - range check, stall, mem_r_data register.

Test Plan:
- Store 0x1234_5678 @0x40, idle 2 cycles, load @0x40 -> mem_r_data=0x1234_5678 next cycle; wb_empty=1 before the load.
- Store 0xA @0x80 then immediately load @0x80 (no drain between) -> forwarded 0xA next cycle, from buffer hit.
- Stores 1,2 @0x10 back-to-back, then load @0x10 -> 2 (youngest match).
- After drain, array@0x10 = 2.
- Hold mem_oe=1 every cycle while issuing 5 stores to distinct addresses (WB_DEPTH=4):
  - 5th store sees stall=1;
  - drop mem_oe -> stall=0 that cycle, store accepted, count stays 4.
- Load @0x0001_0000 (ADDR_W=10) -> mem_r_data=0, addr_err=1.
- Store to the same address -> not buffered; addr_err stays 1 until rst.
- Fill 3 stores, assert rst mid-drain -> wb_empty=1 and mem_r_data=0 immediately.
- After release, loads of the undrained addresses return their pre-store array values.
